// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the 4-bit sequence checker.
//   - seq_state_t : checker FSM states
//   - SEQ_*       : the eight legal values in cycle order 0,1,2,3,F,E,D,C
//   - seq_next()  : successor of a legal value (illegal values map to 0)
//   - seq_legal() : 1 when the value is part of the cycle (4..B are illegal)
package seq_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2
  } seq_state_t;

  localparam logic [3:0] SEQ_0 = 4'h0;
  localparam logic [3:0] SEQ_1 = 4'h1;
  localparam logic [3:0] SEQ_2 = 4'h2;
  localparam logic [3:0] SEQ_3 = 4'h3;
  localparam logic [3:0] SEQ_F = 4'hF;
  localparam logic [3:0] SEQ_E = 4'hE;
  localparam logic [3:0] SEQ_D = 4'hD;
  localparam logic [3:0] SEQ_C = 4'hC;

  function automatic logic [3:0] seq_next(input logic [3:0] v);
    logic [3:0] n;
    case (v)
      SEQ_0:   n = SEQ_1;
      SEQ_1:   n = SEQ_2;
      SEQ_2:   n = SEQ_3;
      SEQ_3:   n = SEQ_F;
      SEQ_F:   n = SEQ_E;
      SEQ_E:   n = SEQ_D;
      SEQ_D:   n = SEQ_C;
      SEQ_C:   n = SEQ_0;
      default: n = SEQ_0;
    endcase
    return n;
  endfunction

  function automatic logic seq_legal(input logic [3:0] v);
    return !((v >= 4'h4) && (v <= 4'hB));
  endfunction

endpackage

// File: rtl/seq_next_lut.sv
// seq_next_lut: combinational successor/legality lookup for the
// 0,1,2,3,F,E,D,C cycle. Shared by sequence generators and checkers.
// Ports:
//   v     in  4  value to look up
//   nxt   out 4  expected successor of v (0 when v is illegal)
//   legal out 1  v is one of the eight cycle values
module seq_next_lut
  import seq_pkg::*;
(
  input  logic [3:0] v,
  output logic [3:0] nxt,
  output logic       legal
);

  logic [3:0] nxt_tab [16];
  logic [15:0] legal_tab;

  // Build both 16-entry tables from the package functions so the
  // sequence definition lives in exactly one place.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_tab
      assign nxt_tab[gi]   = seq_next(4'(gi));
      assign legal_tab[gi] = seq_legal(4'(gi));
    end
  endgenerate

  assign nxt   = nxt_tab[v];
  assign legal = legal_tab[v];

endmodule

// File: rtl/seq_checker.sv
// seq_checker: monitors a 4-bit counter output and checks that it follows
// 0,1,2,3,F,E,D,C,0... It locks after LOCK_CNT consecutive correct
// transitions, then flags each deviation, counts errors (saturating) and
// completed laps (C->0 while locked, wrapping).
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-low reset
//   q_in       in  WIDTH  counter value under check
//   valid      in  1      sample q_in this cycle
//   clr_err    in  1      synchronous clear of err_cnt and sticky_err
//   locked     out 1      checker is locked to the sequence
//   err        out 1      one-cycle pulse per deviation while locked
//   sticky_err out 1      set on any error, held until clr_err/reset
//   err_cnt    out CNT_W  saturating error count
//   lap_cnt    out CNT_W  wrapping lap count
module seq_checker
  import seq_pkg::*;
#(
  parameter int WIDTH    = 4,   // only 4 is supported
  parameter int LOCK_CNT = 2,   // 1..15
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             sticky_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] lap_cnt
);

  seq_state_t       state_reg, state_next;
  logic [3:0]       prev_reg, prev_next;
  logic [3:0]       good_reg, good_next;
  logic             locked_reg, locked_next;
  logic             err_reg, err_next;
  logic             sticky_reg, sticky_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] lap_cnt_reg, lap_cnt_next;

  logic [3:0]       prev_succ;
  logic             prev_legal;
  logic [3:0]       q_succ;
  logic             q_legal;
  logic             match;
  logic [3:0]       good_inc;
  logic             lap_inc;
  logic             err_hit;
  logic [CNT_W-1:0] err_base;

  // Expected successor of the last accepted sample.
  seq_next_lut u_prev_lut (
    .v     (prev_reg),
    .nxt   (prev_succ),
    .legal (prev_legal)
  );

  // Legality of the incoming sample.
  seq_next_lut u_q_lut (
    .v     (q_in[3:0]),
    .nxt   (q_succ),
    .legal (q_legal)
  );

  // prev only ever holds legal values; the legality term is a guard in case
  // it ever comes out of reset or a future change with something else.
  assign match    = prev_legal && (q_in[3:0] == prev_succ);
  assign good_inc = good_reg + 4'd1;

  // ---------------- next-state / datapath ----------------
  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    good_next  = good_reg;
    lap_inc    = 1'b0;
    err_hit    = 1'b0;

    case (state_reg)
      UNLOCKED: begin
        if (valid && q_legal) begin
          prev_next  = q_in[3:0];
          good_next  = 4'd0;
          state_next = SYNCING;
        end
      end

      SYNCING: begin
        if (valid) begin
          if (match) begin
            good_next = good_inc;
            prev_next = q_in[3:0];
            if (good_inc >= 4'(LOCK_CNT)) begin
              state_next = LOCKED;
            end
          end else begin
            good_next = 4'd0;
            if (q_legal) begin
              prev_next = q_in[3:0];
            end else begin
              state_next = UNLOCKED;
            end
          end
        end
      end

      LOCKED: begin
        if (valid) begin
          if (match) begin
            prev_next = q_in[3:0];
            if ((prev_reg == SEQ_C) && (q_in[3:0] == SEQ_0)) begin
              lap_inc = 1'b1;
            end
          end else begin
            err_hit   = 1'b1;
            good_next = 4'd0;
            if (q_legal) begin
              prev_next  = q_in[3:0];
              state_next = SYNCING;
            end else begin
              state_next = UNLOCKED;
            end
          end
        end
      end

      default: begin
        state_next = UNLOCKED;
        good_next  = 4'd0;
      end
    endcase
  end

  // ---------------- status / counters ----------------
  // A simultaneous clear and error behaves as clear-then-count, so the
  // error is never lost.
  always_comb begin
    err_base     = clr_err ? '0 : err_cnt_reg;
    err_cnt_next = err_base;
    if (err_hit && (err_base != {CNT_W{1'b1}})) begin
      err_cnt_next = err_base + 1'b1;
    end
    sticky_next  = err_hit | (sticky_reg & ~clr_err);
    err_next     = err_hit;
    lap_cnt_next = lap_cnt_reg + CNT_W'(lap_inc);
    locked_next  = (state_next == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= UNLOCKED;
      prev_reg    <= 4'd0;
      good_reg    <= 4'd0;
      locked_reg  <= 1'b0;
      err_reg     <= 1'b0;
      sticky_reg  <= 1'b0;
      err_cnt_reg <= '0;
      lap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= prev_next;
      good_reg    <= good_next;
      locked_reg  <= locked_next;
      err_reg     <= err_next;
      sticky_reg  <= sticky_next;
      err_cnt_reg <= err_cnt_next;
      lap_cnt_reg <= lap_cnt_next;
    end
  end

  assign locked     = locked_reg;
  assign err        = err_reg;
  assign sticky_err = sticky_reg;
  assign err_cnt    = err_cnt_reg;
  assign lap_cnt    = lap_cnt_reg;

  // The q_in lookup's successor output is not needed here.
  logic unused_ok;
  assign unused_ok = ^q_succ;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       valid;
  logic       clr_err;
  logic       locked;
  logic       err;
  logic       sticky_err;
  logic [7:0] err_cnt;
  logic [7:0] lap_cnt;

  int checks = 0;
  int errors = 0;

  seq_checker #(
    .WIDTH    (4),
    .LOCK_CNT (2),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .valid      (valid),
    .clr_err    (clr_err),
    .locked     (locked),
    .err        (err),
    .sticky_err (sticky_err),
    .err_cnt    (err_cnt),
    .lap_cnt    (lap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] q;
    logic       c;
    logic       lk;
    logic       e;
    logic       st;
    logic [7:0] ec;
    logic [7:0] lap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] q, input logic c,
                     input logic lk, input logic e, input logic st,
                     input logic [7:0] ec, input logic [7:0] lap);
    vec_t t;
    t.v = v; t.q = q; t.c = c; t.lk = lk; t.e = e; t.st = st; t.ec = ec; t.lap = lap;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one sample and return 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [3:0] q, input logic c);
    valid   = v;
    q_in    = q;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic e, input logic st,
                         input logic [7:0] ec, input logic [7:0] lap);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".sticky"}, 32'(sticky_err), 32'(st));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, ".lap_cnt"}, 32'(lap_cnt), 32'(lap));
    $display("%s: locked=%0d err=%0d sticky=%0d err_cnt=%0d lap_cnt=%0d",
             tag, locked, err, sticky_err, err_cnt, lap_cnt);
  endtask

  initial begin
    logic [3:0] seq_vals [12];
    logic [3:0] lap_vals [8];

    // v  q     c   lk e st ec lap
    add(1, 4'h0, 0, 0, 0, 0, 0, 0);  // UNLOCKED -> SYNCING
    add(1, 4'h1, 0, 0, 0, 0, 0, 0);
    add(1, 4'h2, 0, 1, 0, 0, 0, 0);  // second match -> locked
    add(1, 4'h3, 0, 1, 0, 0, 0, 0);
    add(1, 4'hF, 0, 1, 0, 0, 0, 0);
    add(1, 4'hE, 0, 1, 0, 0, 0, 0);
    add(1, 4'hD, 0, 1, 0, 0, 0, 0);
    add(1, 4'hC, 0, 1, 0, 0, 0, 0);
    add(1, 4'h0, 0, 1, 0, 0, 0, 1);  // C->0 lap
    add(0, 4'h5, 0, 1, 0, 0, 0, 1);  // invalid cycle ignored
    add(1, 4'h1, 0, 1, 0, 0, 0, 1);
    add(1, 4'h2, 0, 1, 0, 0, 0, 1);
    add(1, 4'h5, 0, 0, 1, 1, 1, 1);  // illegal -> UNLOCKED
    add(0, 4'h0, 0, 0, 0, 1, 1, 1);  // pulse drops
    add(1, 4'h0, 0, 0, 0, 1, 1, 1);
    add(1, 4'h1, 0, 0, 0, 1, 1, 1);
    add(1, 4'h2, 0, 1, 0, 1, 1, 1);  // relocked
    add(1, 4'h3, 0, 1, 0, 1, 1, 1);
    add(1, 4'h2, 0, 0, 1, 1, 2, 1);  // legal wrong -> SYNCING prev=2
    add(1, 4'h3, 0, 0, 0, 1, 2, 1);
    add(1, 4'hF, 0, 1, 0, 1, 2, 1);  // locked again after 2 matches
    add(1, 4'hE, 1, 1, 0, 0, 0, 1);  // clr alone
    add(1, 4'hD, 0, 1, 0, 0, 0, 1);
    add(1, 4'h7, 0, 0, 1, 1, 1, 1);
    add(1, 4'hC, 0, 0, 0, 1, 1, 1);
    add(1, 4'h0, 0, 0, 0, 1, 1, 1);  // C->0 while syncing: no lap
    add(1, 4'h1, 0, 1, 0, 1, 1, 1);
    add(1, 4'h3, 1, 0, 1, 1, 1, 1);  // clr + error: error wins
    add(0, 4'h0, 1, 0, 0, 0, 0, 1);  // clr alone

    reset   = 1'b0;
    valid   = 1'b0;
    q_in    = 4'h0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].q, vecs[i].c);
      chk_all($sformatf("vec%0d q=%h v=%0d clr=%0d", i, vecs[i].q, vecs[i].v, vecs[i].c),
              vecs[i].lk, vecs[i].e, vecs[i].st, vecs[i].ec, vecs[i].lap);
    end

    // SYNCING with prev=3: relock, then run to lap_cnt=3 stopping at prev=E.
    step(1, 4'hF, 0);
    step(1, 4'hE, 0);
    step(1, 4'hD, 0);
    step(1, 4'hC, 0);
    step(1, 4'h0, 0);
    seq_vals = '{4'h1, 4'h2, 4'h3, 4'hF, 4'hE, 4'hD, 4'hC, 4'h0,
                 4'h1, 4'h2, 4'h3, 4'hF};
    for (int i = 0; i < 12; i++) step(1, seq_vals[i], 0);
    step(1, 4'hE, 0);
    chk_all("midlap", 1, 0, 0, 0, 3);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h0, 0);
      chk($sformatf("idle%0d.locked", i), 32'(locked), 32'd0);
    end
    // From UNLOCKED, 1,2 is only one match; 3 completes the lock.
    step(1, 4'h1, 0);
    step(1, 4'h2, 0);
    chk_all("post_reset_2", 0, 0, 0, 0, 0);
    step(1, 4'h3, 0);
    chk_all("post_reset_3", 1, 0, 0, 0, 0);

    // Error counter saturation: each round = one error + relock.
    for (int r = 0; r < 254; r++) begin
      step(1, 4'h5, 0);
      step(1, 4'h0, 0);
      step(1, 4'h1, 0);
      step(1, 4'h2, 0);
    end
    chk_all("err_254", 1, 0, 1, 254, 0);
    step(1, 4'h5, 0);
    chk_all("err_255", 0, 1, 1, 255, 0);
    step(1, 4'h0, 0);
    step(1, 4'h1, 0);
    step(1, 4'h2, 0);
    step(1, 4'h5, 0);
    chk_all("err_sat", 0, 1, 1, 255, 0);
    step(1, 4'h0, 0);
    step(1, 4'h1, 0);
    step(1, 4'h2, 0);
    chk_all("relock_sat", 1, 0, 1, 255, 0);

    // Lap counter wrap.
    lap_vals = '{4'h3, 4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'h1, 4'h2};
    for (int l = 0; l < 255; l++) begin
      for (int k = 0; k < 8; k++) step(1, lap_vals[k], 0);
    end
    chk_all("lap_255", 1, 0, 1, 255, 255);
    for (int k = 0; k < 6; k++) step(1, lap_vals[k], 0);
    chk_all("lap_wrap", 1, 0, 1, 255, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Downstream monitor for the 4-bit up/down sequence counter. Samples the counter's `q` output and checks that it follows the fixed cycle 0→1→2→3→F→E→D→C→0. Locks onto the stream after a run of correct transitions, then flags every deviation, counts errors and completed laps. Sits directly on the counter's output bus and feeds status and LEDs.

## Interface
- `WIDTH`, 4: sample width; only 4 is supported.
- `LOCK_CNT`, 2: number of consecutive correct transitions needed to lock; range 1–15.
- `CNT_W`, 8: width of the error and lap counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `q_in`  in  WIDTH  counter value under check.
- `valid`  in  1  sample `q_in` this cycle; ignored when 0.
- `clr_err`  in  1  synchronous clear of `err_cnt` and `sticky_err`.
- `locked`  out  1  checker is locked to the sequence.
- `err`  out  1  one-cycle pulse per detected deviation.
- `sticky_err`  out  1  set on any error; held until `clr_err` or reset.
- `err_cnt`  out  CNT_W  saturating error count.
- `lap_cnt`  out  CNT_W  wrapping count of C→0 transitions while locked.

## Operation
- Legal values: {0,1,2,3,C,D,E,F}. Values 4–B are illegal. next(v): 0→1, 1→2, 2→3, 3→F, F→E, E→D, D→C, C→0.
- Internal registers: `state`, `prev[3:0]`, `good` (0..LOCK_CNT).
- States:
  - UNLOCKED: on a legal valid sample, set prev=q_in and good=0, then go to SYNCING. Illegal samples are ignored.
  - SYNCING: on a valid sample equal to next(prev), increment good and set prev=q_in. When good reaches LOCK_CNT, go to LOCKED. On a mismatch, set good=0. If the sample is legal, set prev=q_in and stay in SYNCING; otherwise go to UNLOCKED. Mismatches here are not errors.
  - LOCKED: on a match, set prev=q_in. If prev was C and q_in is 0, increment lap_cnt (wrapping). On a mismatch, pulse err, saturating-increment err_cnt, set sticky_err, and set good=0. If the sample is legal, set prev=q_in and go to SYNCING; otherwise go to UNLOCKED.
- A cycle with valid=0 changes nothing except the err pulse, which falls back to 0.
- `clr_err` together with an error in the same cycle: the error wins, so err_cnt=1 and sticky_err=1.
- `clr_err` alone: err_cnt=0, sticky_err=0. It does not affect lap_cnt or locked.
- err_cnt saturates at 2^CNT_W−1. lap_cnt wraps to 0.

## Timing
- Reset values: state=UNLOCKED, locked=0, err=0, sticky_err=0, err_cnt=0, lap_cnt=0, prev=0, good=0. Reset acts immediately, including mid-lock or mid-pulse.
- All outputs are registered. A sample taken at edge N is reflected at edge N+1.
- `locked` rises in the cycle after the LOCK_CNT-th matching sample. It falls in the cycle after the offending sample.
- `err` is high for exactly one cycle per error. Back-to-back errors give consecutive pulses.
- No handshake: the checker never stalls and accepts every cycle.

## Structure
- Package `seq_pkg`:
  - state enum {UNLOCKED, SYNCING, LOCKED};
  - the sequence constants 0,1,2,3,F,E,D,C;
  - function `seq_next(v)`;
  - function `seq_legal(v)`.
- Sub-module `seq_next_lut` (combinational): input v, outputs nxt[3:0] and legal. It is shared with any future generator or checker.
- Top level: FSM, prev/good registers, saturating and wrapping counters.

## Test plan
- Reset, then feed 0,1,2,3 with valid=1 and LOCK_CNT=2 → locked=1 one cycle after the sample 2; err=0 throughout.
- While locked, feed F,E,D,C,0 → lap_cnt goes 0→1 one cycle after the 0 sample; err_cnt stays 0.
- While locked, after 2 inject 5 → err pulses once, err_cnt=1, sticky_err=1, locked=0, state UNLOCKED. Then feed 0,1,2 → relocks.
- While locked, after 3 inject 2 (legal, wrong) → err pulse, state SYNCING with prev=2. Then feed 3,F → locked again.
- With err_cnt=1, assert clr_err in the same cycle as a new error → err_cnt=1, sticky_err=1. Then clr_err alone → err_cnt=0, sticky_err=0.
- Drive reset low mid-lap (prev=E, lap_cnt=3) → all outputs 0 immediately. After release, valid=0 for 5 cycles → state stays UNLOCKED.
